// File: rtl/sy_pkg.sv
// Shared front-end types: address width, BTB index geometry, BTB update record.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package sy_pkg;

  localparam int AWTH        = 32;
  // BTB geometry shared by the BTB array and its update controller.
  localparam int BTB_IDX_LSB = 4;
  localparam int BTB_IDX_WTH = 9;

  typedef struct packed {
    logic            vld;
    logic [AWTH-1:0] pc;
    logic [AWTH-1:0] target_address;
  } btb_update_t;

endpackage

// File: rtl/sy_ppl_btb_upd_fifo.sv
// Two-write, one-read FIFO of BTB updates with occupancy count.
// Latency: a written entry is visible at the head on the following cycle.
// Backpressure: none internally; the caller must never write more entries than DEPTH - count.
module sy_ppl_btb_upd_fifo
  import sy_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       clr_i,
  input  logic                       wr0_vld_i,
  input  btb_update_t                wr0_dat_i,
  input  logic                       wr1_vld_i,
  input  btb_update_t                wr1_dat_i,
  input  logic                       rd_i,
  output btb_update_t                rd_dat_o,
  output logic [$clog2(DEPTH):0]     count_o,
  output logic                       full_o,
  output logic                       empty_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  btb_update_t         mem_q [DEPTH];
  btb_update_t         mem_d [DEPTH];
  logic [PW-1:0]       wptr_q, wptr_d;
  logic [PW-1:0]       rptr_q, rptr_d;
  logic [CW-1:0]       count_q, count_d;
  logic [PW-1:0]       wptr_nx;

  // Next-state for storage, pointers and count; clear overrides everything.
  always_comb begin
    mem_d   = mem_q;
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    wptr_nx = wptr_q + PW'(1);
    if (clr_i) begin
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = '0;
    end else begin
      // Slot 1 is only ever used together with slot 0, so it lands right behind it.
      if (wr0_vld_i) mem_d[wptr_q]  = wr0_dat_i;
      if (wr1_vld_i) mem_d[wptr_nx] = wr1_dat_i;
      wptr_d  = wptr_q + PW'(wr0_vld_i) + PW'(wr1_vld_i);
      rptr_d  = rptr_q + PW'(rd_i);
      count_d = count_q + CW'(wr0_vld_i) + CW'(wr1_vld_i) - CW'(rd_i);
    end
  end

  // State registers.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= mem_d[i];
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  assign rd_dat_o = mem_q[rptr_q];
  assign count_o  = count_q;
  assign full_o   = (count_q == CW'(DEPTH));
  assign empty_o  = (count_q == '0);

endmodule

// File: rtl/sy_ppl_btb_upd_ctrl.sv
// Funnels dual-slot retire BTB updates into the single BTB write port (merge, queue, defer, drop count).
// Latency: 2 cycles input to btb_update_o when idle, 3 when the head is deferred by a fetch index collision.
// Backpressure: none upstream; updates arriving with no free entry are dropped and counted.
module sy_ppl_btb_upd_ctrl
  import sy_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int IDX_WTH = BTB_IDX_WTH,
  parameter int IDX_LSB = BTB_IDX_LSB,
  parameter int CNT_WTH = 16
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                flush_i,
  input  btb_update_t         upd0_i,
  input  btb_update_t         upd1_i,
  input  logic [AWTH-1:0]     fetch_vaddr_i,
  output btb_update_t         btb_update_o,
  output logic [CNT_WTH-1:0]  drop_cnt_o,
  output logic                busy_o
);

  localparam int CW = $clog2(DEPTH) + 1;

  if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
    $error("sy_ppl_btb_upd_ctrl: DEPTH must be a power of 2 and at least 2");
  end

  btb_update_t          out_q, out_d;
  logic                 defer_q, defer_d;
  logic [CNT_WTH-1:0]   drop_q, drop_d;

  logic                 cand0, cand1;
  logic                 wr0_vld, wr1_vld;
  btb_update_t          wr0_dat, wr1_dat;
  logic [1:0]           n_drop;
  logic [CW-1:0]        free;
  logic [CNT_WTH:0]     drop_sum;

  btb_update_t          head;
  logic [CW-1:0]        fifo_count;
  logic                 fifo_full, fifo_empty;
  logic                 pop;
  logic                 collide;

  logic                 unused_bits;
  assign unused_bits = ^{fifo_full, fetch_vaddr_i};

  // Merge, compact and admit retire candidates against the free space seen at cycle start.
  always_comb begin
    // Younger slot wins a same-PC pair; the older one is silently superseded.
    cand0   = upd0_i.vld & ~(upd1_i.vld & (upd0_i.pc == upd1_i.pc)) & ~flush_i;
    cand1   = upd1_i.vld & ~flush_i;
    free    = CW'(DEPTH) - fifo_count;
    wr0_vld = 1'b0;
    wr1_vld = 1'b0;
    wr0_dat = upd0_i;
    wr1_dat = upd1_i;
    n_drop  = 2'd0;
    if (cand0 && cand1) begin
      if (free >= CW'(2)) begin
        wr0_vld = 1'b1;
        wr1_vld = 1'b1;
      end else if (free == CW'(1)) begin
        wr0_vld = 1'b1;
        n_drop  = 2'd1;
      end else begin
        n_drop  = 2'd2;
      end
    end else if (cand0 || cand1) begin
      wr0_dat = cand0 ? upd0_i : upd1_i;
      if (free != '0) wr0_vld = 1'b1;
      else            n_drop  = 2'd1;
    end
  end

  // Head drain: yield once to a colliding fetch read, then write regardless.
  always_comb begin
    collide = (head.pc[IDX_LSB +: IDX_WTH] == fetch_vaddr_i[IDX_LSB +: IDX_WTH]);
    out_d   = '0;
    defer_d = defer_q;
    pop     = 1'b0;
    if (flush_i) begin
      defer_d = 1'b0;
    end else if (!fifo_empty) begin
      if (collide && !defer_q) begin
        defer_d = 1'b1;
      end else begin
        pop       = 1'b1;
        out_d     = head;
        out_d.vld = 1'b1;
        defer_d   = 1'b0;
      end
    end
  end

  // Saturating drop counter; survives flush so lost training is still visible.
  always_comb begin
    drop_sum = {1'b0, drop_q} + (CNT_WTH + 1)'(n_drop);
    drop_d   = drop_sum[CNT_WTH] ? '1 : drop_sum[CNT_WTH-1:0];
  end

  // Output, defer flag and drop counter registers.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      out_q   <= '0;
      defer_q <= 1'b0;
      drop_q  <= '0;
    end else begin
      out_q   <= out_d;
      defer_q <= defer_d;
      drop_q  <= drop_d;
    end
  end

  sy_ppl_btb_upd_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .clr_i     (flush_i),
    .wr0_vld_i (wr0_vld),
    .wr0_dat_i (wr0_dat),
    .wr1_vld_i (wr1_vld),
    .wr1_dat_i (wr1_dat),
    .rd_i      (pop),
    .rd_dat_o  (head),
    .count_o   (fifo_count),
    .full_o    (fifo_full),
    .empty_o   (fifo_empty)
  );

  assign btb_update_o = out_q;
  assign drop_cnt_o   = drop_q;
  assign busy_o       = ~fifo_empty | out_q.vld;

endmodule

// File: tb/tb_sy_ppl_btb_upd_ctrl.sv
// Bench for the BTB update controller: directed scenarios plus randomized traffic against a queue model.
// Latency: n/a.
// Backpressure: n/a.
module tb_sy_ppl_btb_upd_ctrl;
  import sy_pkg::*;

  localparam int DEPTH   = 4;
  localparam int IDX_WTH = 9;
  localparam int IDX_LSB = 4;
  // Narrow drop counter so saturation is reachable in a short run.
  localparam int CNT_WTH = 10;
  localparam int CNT_MAX = (1 << CNT_WTH) - 1;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               flush;
  btb_update_t        upd0, upd1, out;
  logic [AWTH-1:0]    fetch;
  logic [CNT_WTH-1:0] drop;
  logic               busy;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  sy_ppl_btb_upd_ctrl #(
    .DEPTH   (DEPTH),
    .IDX_WTH (IDX_WTH),
    .IDX_LSB (IDX_LSB),
    .CNT_WTH (CNT_WTH)
  ) dut (
    .clk_i         (clk),
    .rst_i         (rst_n),
    .flush_i       (flush),
    .upd0_i        (upd0),
    .upd1_i        (upd1),
    .fetch_vaddr_i (fetch),
    .btb_update_o  (out),
    .drop_cnt_o    (drop),
    .busy_o        (busy)
  );

  // ---------------- reference model: a plain queue of pending updates ----------------
  btb_update_t m_q[$];
  bit          m_defer;
  btb_update_t m_out;
  int          m_drop;

  function automatic int idx_of(logic [AWTH-1:0] a);
    return int'((a >> IDX_LSB) % (1 << IDX_WTH));
  endfunction

  function automatic btb_update_t mk(logic [AWTH-1:0] pc, logic [AWTH-1:0] tgt);
    btb_update_t u;
    u.vld = 1'b1;
    u.pc = pc;
    u.target_address = tgt;
    return u;
  endfunction

  task automatic model_reset();
    m_q.delete();
    m_defer = 0;
    m_out = '0;
    m_drop = 0;
  endtask

  task automatic model_step();
    btb_update_t cands[$];
    int free;
    if (flush) begin
      m_q.delete();
      m_defer = 0;
      m_out = '0;
      return;
    end
    if (upd0.vld && !(upd1.vld && upd1.pc == upd0.pc)) cands.push_back(upd0);
    if (upd1.vld) cands.push_back(upd1);
    free = DEPTH - m_q.size();
    m_out = '0;
    if (m_q.size() > 0) begin
      if (idx_of(m_q[0].pc) == idx_of(fetch) && !m_defer) begin
        m_defer = 1;
      end else begin
        m_out = m_q.pop_front();
        m_out.vld = 1'b1;
        m_defer = 0;
      end
    end
    foreach (cands[i]) begin
      if (i < free) m_q.push_back(cands[i]);
      else m_drop = (m_drop + 1 > CNT_MAX) ? CNT_MAX : m_drop + 1;
    end
  endtask

  function automatic bit m_busy();
    return (m_q.size() != 0) || m_out.vld;
  endfunction

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic idle();
    upd0  = '0;
    upd1  = '0;
    flush = 1'b0;
    fetch = '0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    idle();
    repeat (2) @(posedge clk);
    #1;
    n_chk++;
    if (out !== '0) $display("FAIL reset_out: got %h want 0", out); else n_pass++;
    n_chk++;
    if (drop !== '0) $display("FAIL reset_drop: got %0d want 0", drop); else n_pass++;
    n_chk++;
    if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else n_pass++;
    model_reset();
    rst_n = 1'b1;
  endtask

  task automatic test_single();
    btb_update_t e;
    e = mk(32'h1000, 32'h2000);
    upd0 = e;
    tick();
    idle();
    n_chk++;
    if (out.vld !== 1'b0) $display("FAIL single_no_early: got vld %b want 0", out.vld); else n_pass++;
    tick();
    n_chk++;
    if (out !== e) $display("FAIL single_out: got %h want %h", out, e); else n_pass++;
    tick();
    tick();
    n_chk++;
    if (busy !== 1'b0 || out.vld !== 1'b0)
      $display("FAIL single_idle: got busy %b vld %b want 0 0", busy, out.vld);
    else n_pass++;
  endtask

  task automatic test_merge();
    int d0, nv;
    logic [AWTH-1:0] tgt;
    d0 = int'(drop);
    nv = 0;
    tgt = '0;
    upd0 = mk(32'h1000, 32'h2000);
    upd1 = mk(32'h1000, 32'h3000);
    tick();
    idle();
    for (int i = 0; i < 6; i++) begin
      tick();
      if (out.vld) begin
        nv++;
        tgt = out.target_address;
      end
    end
    n_chk++;
    if (nv != 1 || tgt !== 32'h3000)
      $display("FAIL merge_out: got %0d outputs tgt %h want 1 tgt 00003000", nv, tgt);
    else n_pass++;
    n_chk++;
    if (int'(drop) != d0) $display("FAIL merge_drop: got %0d want %0d", drop, d0); else n_pass++;
  endtask

  task automatic test_defer();
    int at;
    at = -1;
    fetch = 32'h5230;
    upd0 = mk(32'h1230, 32'h4444);
    tick();
    upd0 = '0;
    for (int i = 2; i <= 8; i++) begin
      tick();
      if (out.vld && at < 0) at = i;
    end
    // enqueue edge is tick 1; undeferred issue would show after tick 2
    n_chk++;
    if (at != 3) $display("FAIL defer_latency: got tick %0d want 3", at); else n_pass++;
    idle();
    tick();
  endtask

  task automatic test_burst();
    logic [AWTH-1:0] got[$];
    logic [AWTH-1:0] want[8];
    int d0;
    want = '{32'h100, 32'h110, 32'h120, 32'h130, 32'h140, 32'h160, 32'h180, 32'h1A0};
    d0 = int'(drop);
    for (int c = 0; c < 6; c++) begin
      upd0 = mk(32'h100 + 32'(c * 32), 32'h8100 + 32'(c * 32));
      upd1 = mk(32'h110 + 32'(c * 32), 32'h8110 + 32'(c * 32));
      tick();
      if (out.vld) got.push_back(out.pc);
      n_chk++;
      if (out !== m_out) $display("FAIL burst_out: got %h want %h", out, m_out); else n_pass++;
    end
    idle();
    for (int i = 0; i < 10; i++) begin
      tick();
      if (out.vld) got.push_back(out.pc);
    end
    n_chk++;
    if (int'(drop) - d0 != 4) $display("FAIL burst_drop: got %0d want 4", int'(drop) - d0); else n_pass++;
    n_chk++;
    if (got.size() != 8) $display("FAIL burst_count: got %0d want 8", got.size());
    else begin
      bit ok = 1;
      foreach (want[i]) if (got[i] !== want[i]) ok = 0;
      if (!ok) $display("FAIL burst_order: got %p want %p", got, want); else n_pass++;
    end
  endtask

  task automatic test_flush();
    int d0, nv;
    for (int c = 0; c < 2; c++) begin
      upd0 = mk(32'h300 + 32'(c * 32), 32'h1);
      upd1 = mk(32'h310 + 32'(c * 32), 32'h2);
      tick();
    end
    d0 = int'(drop);
    flush = 1'b1;
    upd0 = mk(32'h700, 32'h3);
    upd1 = mk(32'h710, 32'h4);
    tick();
    idle();
    n_chk++;
    if (busy !== 1'b0 || out.vld !== 1'b0)
      $display("FAIL flush_idle: got busy %b vld %b want 0 0", busy, out.vld);
    else n_pass++;
    nv = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (out.vld) nv++;
    end
    n_chk++;
    if (nv != 0) $display("FAIL flush_no_out: got %0d outputs want 0", nv); else n_pass++;
    n_chk++;
    if (int'(drop) != d0) $display("FAIL flush_drop: got %0d want %0d", drop, d0); else n_pass++;
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      upd0.vld = 1'($urandom_range(0, 1));
      upd0.pc = (32'($urandom_range(0, 1)) << 14) | (32'($urandom_range(0, 3)) << IDX_LSB);
      upd0.target_address = $urandom;
      upd1.vld = 1'($urandom_range(0, 1));
      upd1.pc = (32'($urandom_range(0, 1)) << 14) | (32'($urandom_range(0, 3)) << IDX_LSB);
      upd1.target_address = $urandom;
      fetch = (32'($urandom_range(0, 3)) << 14) | (32'($urandom_range(0, 3)) << IDX_LSB);
      flush = ($urandom_range(0, 19) == 0);
      tick();
      n_chk++;
      if (out !== m_out) $display("FAIL rand_out[%0d]: got %h want %h", i, out, m_out); else n_pass++;
      n_chk++;
      if (int'(drop) != m_drop) $display("FAIL rand_drop[%0d]: got %0d want %0d", i, drop, m_drop); else n_pass++;
      n_chk++;
      if (busy !== m_busy()) $display("FAIL rand_busy[%0d]: got %b want %b", i, busy, m_busy()); else n_pass++;
    end
    idle();
    repeat (6) tick();
  endtask

  task automatic test_saturate();
    int extra;
    extra = 0;
    for (int i = 0; i < 6000 && extra < 6; i++) begin
      upd0 = mk(32'h2000 + 32'((2 * i % 64) << IDX_LSB), 32'h5);
      upd1 = mk(32'h2000 + 32'(((2 * i + 1) % 64) << IDX_LSB), 32'h6);
      tick();
      if (m_drop == CNT_MAX) extra++;
      if (m_drop >= CNT_MAX - 2) begin
        n_chk++;
        if (int'(drop) != m_drop) $display("FAIL sat_track: got %0d want %0d", drop, m_drop); else n_pass++;
      end
    end
    n_chk++;
    if (drop !== CNT_WTH'(CNT_MAX)) $display("FAIL sat_value: got %0d want %0d", drop, CNT_MAX); else n_pass++;
  endtask

  task automatic test_async_reset();
    upd0 = mk(32'h900, 32'h7);
    upd1 = mk(32'h910, 32'h8);
    tick();
    tick();
    idle();
    n_chk++;
    if (out.vld !== 1'b1) $display("FAIL areset_pre: got vld %b want 1", out.vld); else n_pass++;
    #2 rst_n = 1'b0;
    #1;
    n_chk++;
    if (out !== '0 || drop !== '0 || busy !== 1'b0)
      $display("FAIL areset_clear: got out %h drop %0d busy %b want 0 0 0", out, drop, busy);
    else n_pass++;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    test_reset();
    test_single();
    test_merge();
    test_defer();
    test_burst();
    test_flush();
    test_random();
    test_saturate();
    test_async_reset();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
